// File: rtl/cast128_cbc_ctrl_if.sv
`timescale 1ns/1ps
// cast128_cbc_ctrl_if: host-side and core-side signal bundle for the CBC
// front-end. The master modport is the environment (host plus CAST128 core);
// the slave modport is the chaining controller itself.
// Build macro CBC_ECB_MODE_EN adds the per-block ECB bypass input.
interface cast128_cbc_ctrl_if;
    // host side
    logic         IVrdy;
    logic [63:0]  IVin;
    logic         Krdy;
    logic [127:0] Kin;
    logic         Drdy;
    logic         EncDec;
    logic [63:0]  Din;
`ifdef CBC_ECB_MODE_EN
    logic         ECB;
`endif
    logic         BSY;
    logic         Dvld;
    logic [63:0]  Dout;
    logic         ERR;
    // core side
    logic         core_Krdy;
    logic [127:0] core_Kin;
    logic         core_Drdy;
    logic         core_EncDec;
    logic [63:0]  core_Din;
    logic         core_Kvld;
    logic         core_Dvld;
    logic [63:0]  core_Dout;

    modport master (
        output IVrdy, IVin, Krdy, Kin, Drdy, EncDec, Din,
`ifdef CBC_ECB_MODE_EN
        output ECB,
`endif
        input  BSY, Dvld, Dout, ERR,
        input  core_Krdy, core_Kin, core_Drdy, core_EncDec, core_Din,
        output core_Kvld, core_Dvld, core_Dout
    );

    modport slave (
        input  IVrdy, IVin, Krdy, Kin, Drdy, EncDec, Din,
`ifdef CBC_ECB_MODE_EN
        input  ECB,
`endif
        output BSY, Dvld, Dout, ERR,
        output core_Krdy, core_Kin, core_Drdy, core_EncDec, core_Din,
        input  core_Kvld, core_Dvld, core_Dout
    );
endinterface

// File: rtl/cast128_cbc_ctrl.sv
`timescale 1ns/1ps
// cast128_cbc_ctrl: CBC chaining controller sitting in front of a CAST128
// core. Host blocks are XORed with the chain value (encrypt) before issue,
// core results are XORed with the chain value (decrypt) on return, and key
// loads are forwarded with key-validity tracking. A stalled core is detected
// with a bounded wait counter.
// Build macro CBC_ECB_MODE_EN adds an ECB input that bypasses chaining.
module cast128_cbc_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    cast128_cbc_ctrl_if.slave bus
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_n;

    logic [63:0]  chain;
    logic [63:0]  iv;
    logic [63:0]  din_l;
    logic [63:0]  dout_r;
    logic [63:0]  core_din_r;
    logic [127:0] core_kin_r;
    logic         key_valid;
    logic         kpend;
    logic         err_r;
    logic         dvld_r;
    logic         core_krdy_r;
    logic         dec_l;
    logic         ecb_l;
    logic [7:0]   wait_cnt;
    logic         ecb_in;

    // decoded events for the current cycle
    logic         take_iv;
    logic         take_key;
    logic         take_blk;
    logic         drop_blk;
    logic         take_rsp;
    logic         tmo;

    // Chain XOR, skipped when the side in question does not chain.
    function automatic logic [63:0] chain_xor(input logic [63:0] data,
                                              input logic [63:0] cv,
                                              input logic        bypass);
        return bypass ? data : (data ^ cv);
    endfunction

`ifdef CBC_ECB_MODE_EN
    assign ecb_in = bus.ECB;
`else
    assign ecb_in = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and event decode; in IDLE only the highest-priority request wins.
    always_comb begin
        state_n  = state;
        take_iv  = 1'b0;
        take_key = 1'b0;
        take_blk = 1'b0;
        drop_blk = 1'b0;
        take_rsp = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IVrdy) begin
                    take_iv = 1'b1;
                end else if (bus.Krdy) begin
                    take_key = 1'b1;
                end else if (bus.Drdy) begin
                    if (key_valid && !kpend) begin
                        take_blk = 1'b1;
                        state_n  = ISSUE;
                    end else begin
                        drop_blk = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.core_Dvld) begin
                    take_rsp = 1'b1;
                    state_n  = IDLE;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Key tracking: a new load invalidates the key until the core reports completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_valid   <= 1'b0;
            kpend       <= 1'b0;
            core_krdy_r <= 1'b0;
            core_kin_r  <= '0;
        end else begin
            core_krdy_r <= take_key;
            if (take_key) begin
                core_kin_r <= bus.Kin;
                key_valid  <= 1'b0;
                kpend      <= 1'b1;
            end else if (kpend && bus.core_Kvld) begin
                key_valid <= 1'b1;
                kpend     <= 1'b0;
            end
        end
    end

    // Block path: latch and pre-XOR on accept, post-XOR and chain update on result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain      <= '0;
            iv         <= '0;
            din_l      <= '0;
            dec_l      <= 1'b0;
            ecb_l      <= 1'b0;
            core_din_r <= '0;
            dout_r     <= '0;
            dvld_r     <= 1'b0;
            err_r      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            dvld_r <= take_rsp;
            if (take_iv) begin
                chain <= bus.IVin;
                iv    <= bus.IVin;
                err_r <= 1'b0;
            end
            if (drop_blk) begin
                err_r <= 1'b1;
            end
            if (take_blk) begin
                din_l      <= bus.Din;
                dec_l      <= bus.EncDec;
                ecb_l      <= ecb_in;
                core_din_r <= chain_xor(bus.Din, chain, bus.EncDec || ecb_in);
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (take_rsp) begin
                dout_r <= chain_xor(bus.core_Dout, chain, !dec_l || ecb_l);
                if (!ecb_l) begin
                    chain <= dec_l ? din_l : bus.core_Dout;
                end
            end
            if (tmo) begin
                err_r <= 1'b1;
                chain <= iv;
            end
        end
    end

    assign bus.BSY         = (state != IDLE) || kpend;
    assign bus.Dvld        = dvld_r;
    assign bus.Dout        = dout_r;
    assign bus.ERR         = err_r;
    assign bus.core_Krdy   = core_krdy_r;
    assign bus.core_Kin    = core_kin_r;
    assign bus.core_Drdy   = (state == ISSUE);
    assign bus.core_EncDec = dec_l;
    assign bus.core_Din    = core_din_r;
endmodule

// File: tb/tb_cast128_cbc_ctrl.sv
`timescale 1ns/1ps
// tb_cast128_cbc_ctrl: randomized bench for the CBC front-end. A stand-in
// core (invertible toy cipher plus the known CAST128 vector) answers the
// controller; a CBC reference model derives every expected result.
module tb_cast128_cbc_ctrl;
    localparam int TIMEOUT = 32;
    localparam logic [127:0] KEY0 = 128'h0123456712345678234567893456789a;
    localparam logic [63:0]  PT0  = 64'h0123456789abcdef;
    localparam logic [63:0]  CT0  = 64'h238b4fe5847e44b2;
    localparam logic [63:0]  PT1  = 64'h22a80a820dd5895d;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cast128_cbc_ctrl_if bus();
    cast128_cbc_ctrl #(.TIMEOUT(TIMEOUT)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // core stand-in controls
    int core_delay = 2;
    int key_delay  = 2;
    bit core_hold  = 1'b0;
    int stray_req  = 0;
    bit ecb_drv    = 1'b0;

    // reference model state
    logic [63:0]  ref_chain = '0;
    logic [63:0]  ref_iv    = '0;
    logic [127:0] ref_key   = '0;

    function automatic logic [63:0] ref_enc(input logic [127:0] k, input logic [63:0] x);
        logic [63:0] kk;
        kk = k[127:64] ^ k[63:0];
        if (k == KEY0 && x == PT0) return CT0;
        return {x[50:0], x[63:51]} ^ kk;
    endfunction

    function automatic logic [63:0] ref_dec(input logic [127:0] k, input logic [63:0] y);
        logic [63:0] kk;
        logic [63:0] t;
        kk = k[127:64] ^ k[63:0];
        if (k == KEY0 && y == CT0) return PT0;
        t = y ^ kk;
        return {t[12:0], t[63:13]};
    endfunction

    // Stand-in CAST128 core: answers key loads and block requests after a delay.
    initial begin : core_model
        int d_timer;
        int k_timer;
        bit d_busy;
        bit k_busy;
        int stray_done;
        logic [63:0]  d_data;
        logic [127:0] core_key;
        d_timer = 0; k_timer = 0; d_busy = 0; k_busy = 0; stray_done = 0;
        d_data = '0; core_key = '0;
        bus.core_Dvld = 1'b0;
        bus.core_Kvld = 1'b0;
        bus.core_Dout = '0;
        forever begin
            @(negedge clk);
            bus.core_Dvld = 1'b0;
            bus.core_Kvld = 1'b0;
            if (d_busy) begin
                if (d_timer <= 0) begin
                    bus.core_Dvld = 1'b1;
                    bus.core_Dout = d_data;
                    d_busy = 0;
                end else begin
                    d_timer--;
                end
            end else if (stray_done != stray_req) begin
                bus.core_Dvld = 1'b1;
                bus.core_Dout = 64'h5a5a_a5a5_0f0f_f0f0;
                stray_done++;
            end
            if (k_busy) begin
                if (k_timer <= 0) begin
                    bus.core_Kvld = 1'b1;
                    k_busy = 0;
                end else begin
                    k_timer--;
                end
            end
            if (bus.core_Krdy === 1'b1) begin
                core_key = bus.core_Kin;
                k_busy = 1;
                k_timer = key_delay - 1;
            end
            if (bus.core_Drdy === 1'b1 && !core_hold) begin
                d_busy = 1;
                d_timer = core_delay - 1;
                d_data = bus.core_EncDec ? ref_dec(core_key, bus.core_Din)
                                         : ref_enc(core_key, bus.core_Din);
            end
        end
    end

    // CBC reference: expected host result and expected core input for one block.
    task automatic model_block(input bit dec, input bit ecb, input logic [63:0] din,
                               output logic [63:0] exp, output logic [63:0] cdin);
        if (ecb) begin
            cdin = din;
            exp = dec ? ref_dec(ref_key, din) : ref_enc(ref_key, din);
        end else if (!dec) begin
            cdin = din ^ ref_chain;
            exp = ref_enc(ref_key, cdin);
            ref_chain = exp;
        end else begin
            cdin = din;
            exp = ref_dec(ref_key, din) ^ ref_chain;
            ref_chain = din;
        end
    endtask

    task automatic clear_inputs;
        bus.IVrdy = 1'b0; bus.IVin = '0; bus.Krdy = 1'b0; bus.Kin = '0;
        bus.Drdy = 1'b0; bus.EncDec = 1'b0; bus.Din = '0;
`ifdef CBC_ECB_MODE_EN
        bus.ECB = 1'b0;
`endif
    endtask

    // All drive tasks are entered and left just after a negedge.
    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_chain = '0;
        ref_iv = '0;
    endtask

    task automatic load_iv(input logic [63:0] v);
        bus.IVrdy = 1'b1; bus.IVin = v;
        @(negedge clk);
        bus.IVrdy = 1'b0;
        ref_chain = v;
        ref_iv = v;
    endtask

    task automatic load_key(input logic [127:0] k, output bit ok);
        bus.Krdy = 1'b1; bus.Kin = k;
        @(negedge clk);
        bus.Krdy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.BSY === 1'b0) ok = 1'b1;
        end
        ref_key = k;
    endtask

    task automatic send_block(input bit dec, input logic [63:0] din,
                              output logic [63:0] dout, output logic [63:0] cdin,
                              output int drdy_at, output int dvld_at, output int n_drdy);
        bit got;
        bus.Drdy = 1'b1; bus.EncDec = dec; bus.Din = din;
`ifdef CBC_ECB_MODE_EN
        bus.ECB = ecb_drv;
`endif
        @(negedge clk);
        bus.Drdy = 1'b0;
        got = 0; drdy_at = -1; dvld_at = -1; n_drdy = 0; dout = 'x; cdin = 'x;
        for (int i = 1; i <= 60 && !got; i++) begin
            if (bus.core_Drdy === 1'b1) begin
                n_drdy++;
                if (drdy_at < 0) drdy_at = i;
                cdin = bus.core_Din;
            end
            if (bus.Dvld === 1'b1) begin
                got = 1;
                dvld_at = i;
                dout = bus.Dout;
            end
            if (!got) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++;
        if ({bus.BSY, bus.Dvld, bus.ERR, bus.core_Krdy, bus.core_Drdy, bus.core_EncDec} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.BSY, bus.Dvld, bus.ERR, bus.core_Krdy, bus.core_Drdy, bus.core_EncDec});
        end
        n_checks++;
        if (bus.Dout !== 64'h0) begin
            n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.Dout);
        end
        n_checks++;
        if ({bus.core_Din, bus.core_Kin} !== 192'h0) begin
            n_fail++; $display("FAIL reset_core_bus: got %h/%h expected 0", bus.core_Din, bus.core_Kin);
        end
    endtask

    task automatic test_no_key;
        int seen;
        bus.Drdy = 1'b1; bus.EncDec = 1'b0; bus.Din = PT0;
        @(negedge clk);
        bus.Drdy = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.core_Drdy === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL nokey_issue: got %0d core_Drdy expected 0", seen); end
        n_checks++;
        if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL nokey_err: got %b expected 1", bus.ERR); end
        n_checks++;
        if (bus.BSY !== 1'b0) begin n_fail++; $display("FAIL nokey_bsy: got %b expected 0", bus.BSY); end
        load_iv(64'h0);
        n_checks++;
        if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL iv_clears_err: got %b expected 0", bus.ERR); end
    endtask

    task automatic test_key_load;
        bit ok;
        key_delay = 6;
        bus.Krdy = 1'b1; bus.Kin = KEY0;
        @(negedge clk);
        bus.Krdy = 1'b0;
        n_checks++;
        if ({bus.core_Krdy, bus.BSY} !== 2'b11) begin
            n_fail++; $display("FAIL key_req: got krdy/bsy %b%b expected 11", bus.core_Krdy, bus.BSY);
        end
        n_checks++;
        if (bus.core_Kin !== KEY0) begin n_fail++; $display("FAIL key_fwd: got %h expected %h", bus.core_Kin, KEY0); end
        // a block offered while the key schedule is pending must be dropped
        bus.Drdy = 1'b1; bus.Din = PT0; bus.EncDec = 1'b0;
        @(negedge clk);
        bus.Drdy = 1'b0;
        n_checks++;
        if (bus.core_Krdy !== 1'b0) begin n_fail++; $display("FAIL key_pulse: got %b expected 0", bus.core_Krdy); end
        n_checks++;
        if ({bus.core_Drdy, bus.ERR} !== 2'b01) begin
            n_fail++; $display("FAIL kpend_drop: got drdy/err %b%b expected 01", bus.core_Drdy, bus.ERR);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.BSY === 1'b0) ok = 1'b1;
        end
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL key_done: BSY still %b expected 0", bus.BSY); end
        ref_key = KEY0;
        key_delay = 2;
        load_iv(64'h0);
    endtask

    task automatic test_vectors;
        logic [63:0] dout, cdin, exp, ecd;
        int da, va, nd;
        core_delay = 3;
        load_iv(64'h0);
        model_block(1'b0, 1'b0, PT0, exp, ecd);
        send_block(1'b0, PT0, dout, cdin, da, va, nd);
        n_checks++;
        if (dout !== CT0) begin n_fail++; $display("FAIL vec_enc1: got %h expected %h", dout, CT0); end
        n_checks++;
        if (da !== 1 || va !== core_delay + 2) begin
            n_fail++; $display("FAIL vec_latency: got issue@%0d result@%0d expected 1 and %0d", da, va, core_delay + 2);
        end
        model_block(1'b0, 1'b0, PT1, exp, ecd);
        send_block(1'b0, PT1, dout, cdin, da, va, nd);
        n_checks++;
        if (dout !== CT0) begin n_fail++; $display("FAIL vec_enc2: got %h expected %h", dout, CT0); end
        n_checks++;
        if (cdin !== PT0) begin n_fail++; $display("FAIL vec_enc2_core_din: got %h expected %h", cdin, PT0); end
        load_iv(64'h0);
        model_block(1'b1, 1'b0, CT0, exp, ecd);
        send_block(1'b1, CT0, dout, cdin, da, va, nd);
        n_checks++;
        if (dout !== PT0) begin n_fail++; $display("FAIL vec_dec1: got %h expected %h", dout, PT0); end
        model_block(1'b1, 1'b0, CT0, exp, ecd);
        send_block(1'b1, CT0, dout, cdin, da, va, nd);
        n_checks++;
        if (dout !== PT1) begin n_fail++; $display("FAIL vec_dec2: got %h expected %h", dout, PT1); end
    endtask

    task automatic run_blocks(input int n, input bit rand_delay, input string tag);
        logic [63:0] din, dout, cdin, exp, ecd;
        bit dec;
        int da, va, nd;
        for (int b = 0; b < n; b++) begin
            if (rand_delay) begin
                core_delay = int'($urandom_range(1, 6));
                if ($urandom_range(0, 7) == 0) load_iv({$urandom, $urandom});
            end
            dec = 1'($urandom_range(0, 1));
            din = {$urandom, $urandom};
            model_block(dec, ecb_drv, din, exp, ecd);
            send_block(dec, din, dout, cdin, da, va, nd);
            n_checks++;
            if (dout !== exp) begin n_fail++; $display("FAIL %s_dout[%0d]: got %h expected %h", tag, b, dout, exp); end
            n_checks++;
            if (cdin !== ecd || nd !== 1) begin
                n_fail++; $display("FAIL %s_core_din[%0d]: got %h x%0d expected %h x1", tag, b, cdin, nd, ecd);
            end
            n_checks++;
            if (da !== 1 || va !== core_delay + 2) begin
                n_fail++; $display("FAIL %s_latency[%0d]: got %0d/%0d expected 1/%0d", tag, b, da, va, core_delay + 2);
            end
        end
    endtask

    task automatic test_random_cbc;
        load_iv({$urandom, $urandom});
        run_blocks(40, 1'b1, "rand");
    endtask

    task automatic test_back_to_back;
        core_delay = 1;
        run_blocks(8, 1'b0, "b2b");
    endtask

    task automatic test_busy_ignore;
        logic [63:0] din, exp, ecd, dout;
        int nk, nd;
        bit got;
        core_delay = 5;
        din = {$urandom, $urandom};
        model_block(1'b0, 1'b0, din, exp, ecd);
        bus.Drdy = 1'b1; bus.EncDec = 1'b0; bus.Din = din;
        @(negedge clk);
        bus.Drdy = 1'b0;
        @(negedge clk);
        bus.IVrdy = 1'b1; bus.IVin = {$urandom, $urandom};
        bus.Krdy = 1'b1; bus.Kin = {$urandom, $urandom, $urandom, $urandom};
        bus.Drdy = 1'b1; bus.Din = {$urandom, $urandom};
        @(negedge clk);
        clear_inputs;
        got = 0; nk = 0; nd = 0; dout = 'x;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus.core_Krdy === 1'b1) nk++;
            if (bus.core_Drdy === 1'b1) nd++;
            if (bus.Dvld === 1'b1) begin got = 1; dout = bus.Dout; end
            if (!got) @(negedge clk);
        end
        n_checks++;
        if (dout !== exp) begin n_fail++; $display("FAIL busy_dout: got %h expected %h", dout, exp); end
        n_checks++;
        if (nk !== 0 || nd !== 0 || bus.ERR !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignored: got krdy %0d drdy %0d err %b expected 0 0 0", nk, nd, bus.ERR);
        end
        run_blocks(1, 1'b0, "busy_after");
    endtask

    task automatic test_priority;
        logic [63:0] v;
        int seen;
        bit ok;
        // IV beats block
        v = {$urandom, $urandom};
        bus.IVrdy = 1'b1; bus.IVin = v; bus.Drdy = 1'b1; bus.Din = {$urandom, $urandom};
        @(negedge clk);
        clear_inputs;
        ref_chain = v; ref_iv = v;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.core_Drdy === 1'b1 || bus.BSY === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0 || bus.ERR !== 1'b0) begin
            n_fail++; $display("FAIL prio_iv_drdy: got busy cycles %0d err %b expected 0 0", seen, bus.ERR);
        end
        run_blocks(1, 1'b0, "prio_iv");
        // key beats block
        bus.Krdy = 1'b1; bus.Kin = 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
        bus.Drdy = 1'b1; bus.Din = {$urandom, $urandom};
        @(negedge clk);
        clear_inputs;
        n_checks++;
        if ({bus.core_Krdy, bus.core_Drdy} !== 2'b10) begin
            n_fail++; $display("FAIL prio_key_drdy: got krdy/drdy %b%b expected 10", bus.core_Krdy, bus.core_Drdy);
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.BSY === 1'b0) ok = 1'b1;
        end
        ref_key = 128'hfedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978;
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL prio_key_done: BSY %b expected 0", bus.BSY); end
        run_blocks(1, 1'b0, "prio_key");
        // IV beats key: key must stay as it was
        v = {$urandom, $urandom};
        bus.IVrdy = 1'b1; bus.IVin = v; bus.Krdy = 1'b1; bus.Kin = KEY0;
        @(negedge clk);
        clear_inputs;
        ref_chain = v; ref_iv = v;
        n_checks++;
        if ({bus.core_Krdy, bus.BSY} !== 2'b00) begin
            n_fail++; $display("FAIL prio_iv_key: got krdy/bsy %b%b expected 00", bus.core_Krdy, bus.BSY);
        end
        run_blocks(1, 1'b0, "prio_ivkey");
    endtask

    task automatic test_timeout;
        int err_at;
        bit dv;
        core_hold = 1'b1;
        load_iv({$urandom, $urandom});
        bus.Drdy = 1'b1; bus.EncDec = 1'b0; bus.Din = {$urandom, $urandom};
        @(negedge clk);
        bus.Drdy = 1'b0;
        err_at = -1; dv = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            if (err_at < 0 && bus.ERR === 1'b1) err_at = i;
            if (bus.Dvld === 1'b1) dv = 1;
            @(negedge clk);
        end
        core_hold = 1'b0;
        n_checks++;
        if (err_at !== TIMEOUT + 2) begin
            n_fail++; $display("FAIL timeout_err_cycle: got %0d expected %0d", err_at, TIMEOUT + 2);
        end
        n_checks++;
        if (dv !== 1'b0 || bus.BSY !== 1'b0) begin
            n_fail++; $display("FAIL timeout_quiet: got dvld %b bsy %b expected 0 0", dv, bus.BSY);
        end
        ref_chain = ref_iv;
        run_blocks(1, 1'b0, "timeout_chain");
        n_checks++;
        if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", bus.ERR); end
        load_iv(ref_chain);
    endtask

    task automatic test_rst_mid_wait;
        int dv;
        bit ok;
        core_hold = 1'b1;
        load_iv({$urandom, $urandom} | 64'h1);
        bus.Drdy = 1'b1; bus.EncDec = 1'b0; bus.Din = {$urandom, $urandom};
        @(negedge clk);
        bus.Drdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_chain = '0; ref_iv = '0;
        n_checks++;
        if ({bus.BSY, bus.Dvld, bus.ERR} !== 3'b000 || bus.Dout !== 64'h0) begin
            n_fail++; $display("FAIL rst_wait_state: got bsy/dvld/err %b%b%b dout %h expected 000 0",
                               bus.BSY, bus.Dvld, bus.ERR, bus.Dout);
        end
        stray_req++;
        dv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.Dvld === 1'b1) dv++;
        end
        core_hold = 1'b0;
        n_checks++;
        if (dv !== 0) begin n_fail++; $display("FAIL rst_stray_dvld: got %0d pulses expected 0", dv); end
        load_key(ref_key, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_key_reload: BSY %b expected 0", bus.BSY); end
        run_blocks(1, 1'b0, "rst_chain0");
    endtask

`ifdef CBC_ECB_MODE_EN
    task automatic test_ecb;
        ecb_drv = 1'b1;
        run_blocks(6, 1'b0, "ecb");
        ecb_drv = 1'b0;
        run_blocks(2, 1'b0, "ecb_after");
    endtask
`endif

    initial begin
        clear_inputs;
        @(negedge clk);
        test_reset;
        test_no_key;
        test_key_load;
        test_vectors;
        test_random_cbc;
        test_back_to_back;
        test_busy_ignore;
        test_priority;
        test_timeout;
        test_rst_mid_wait;
`ifdef CBC_ECB_MODE_EN
        test_ecb;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
